wb_fwd_pipe: RTL and testbench

- Parametrised replacement for the fixed EX/MEM → MEM → MEM/WB register chain in the core.
- Carries EX results through DEPTH post-execute stages to the regfile write port, and captures load data at a configurable stage.
- Adds operand forwarding to RD_PORTS decode read ports and a load-use stall request. Neither exists in the current pipeline.
- Sits between ex and regfile, feeding id's operand inputs.

---
 rtl/wb_fwd_pipe_pkg.sv | 36 +++
 rtl/wb_fwd_pipe_fwd_sel.sv | 50 +++++
 rtl/wb_fwd_pipe.sv | 140 ++++++++++++++
 tb/tb_wb_fwd_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fwd_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_fwd_pipe_pkg
// Purpose  : Stage-record layout, zero-register constant and parameter checks
// Revision : 1.0
// ============================================================================
package wb_fwd_pipe_pkg;

  // Stage record bit layout: {data, waddr, ready, load, we, valid}
  localparam int unsigned c_rec_valid    = 0;
  localparam int unsigned c_rec_we       = 1;
  localparam int unsigned c_rec_load     = 2;
  localparam int unsigned c_rec_ready    = 3;
  localparam int unsigned c_rec_addr_lsb = 4;

  localparam int unsigned c_zero_reg = 0;

  function automatic int unsigned rec_width(input int unsigned addr_w,
                                            input int unsigned data_w);
    return c_rec_addr_lsb + addr_w + data_w;
  endfunction

  function automatic int unsigned rec_data_lsb(input int unsigned addr_w);
    return c_rec_addr_lsb + addr_w;
  endfunction

  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned rd_ports,
                                      input int unsigned load_rdy);
    return (depth >= 2) && (depth <= 6) &&
           (rd_ports >= 1) && (rd_ports <= 4) &&
           (load_rdy >= 1) && (load_rdy <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fwd_pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : wb_fwd_pipe_fwd_sel
// Purpose  : Single read-port priority matcher over EX and post-EX records
// Revision : 1.0
// ============================================================================
module wb_fwd_pipe_fwd_sel
  import wb_fwd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned REC_W    = rec_width(ADDR_W, DATA_W),
  localparam int unsigned DATA_LSB = rec_data_lsb(ADDR_W)
) (
  input  logic                           re_i,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic [DATA_W-1:0]              rf_rdata_i,
  input  logic [(DEPTH+1)*REC_W-1:0]     recs_i,
  output logic [DATA_W-1:0]              data_o,
  output logic                           hazard_o
);

  logic w_found;

  // Record 0 is the EX stage, record k is s[k-1]; lowest index is youngest.
  always_comb begin
    data_o   = '0;
    hazard_o = 1'b0;
    w_found  = 1'b0;
    if (re_i && (addr_i != ADDR_W'(c_zero_reg))) begin
      data_o = rf_rdata_i;
      for (int k = 0; k <= int'(DEPTH); k++) begin
        if (!w_found &&
            recs_i[k*REC_W + c_rec_valid] &&
            recs_i[k*REC_W + c_rec_we] &&
            (recs_i[k*REC_W + c_rec_addr_lsb +: ADDR_W] == addr_i)) begin
          w_found = 1'b1;
          if (recs_i[k*REC_W + c_rec_load] && !recs_i[k*REC_W + c_rec_ready]) begin
            hazard_o = 1'b1;
          end else begin
            data_o = recs_i[k*REC_W + DATA_LSB +: DATA_W];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_fwd_pipe
// Purpose  : Parametrised post-EX writeback chain with forwarding and stall
// Revision : 1.0
// ============================================================================
module wb_fwd_pipe
  import wb_fwd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned LOAD_RDY = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold_i,
  input  logic                         flush_i,
  input  logic                         ex_we_i,
  input  logic                         ex_load_i,
  input  logic [ADDR_W-1:0]            ex_waddr_i,
  input  logic [DATA_W-1:0]            ex_wdata_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  input  logic [RD_PORTS-1:0]          rd_re_i,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
  input  logic [RD_PORTS*DATA_W-1:0]   rf_rdata_i,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
  output logic                         stall_req_o,
  output logic                         wb_we_o,
  output logic [ADDR_W-1:0]            wb_waddr_o,
  output logic [DATA_W-1:0]            wb_wdata_o,
  output logic [CNT_W-1:0]             hazard_cnt_o
);

  localparam int unsigned REC_W    = rec_width(ADDR_W, DATA_W);
  localparam int unsigned DATA_LSB = rec_data_lsb(ADDR_W);

  if (!params_legal(DEPTH, RD_PORTS, LOAD_RDY)) begin : g_param_err
    $error("wb_fwd_pipe: illegal DEPTH/RD_PORTS/LOAD_RDY combination");
  end

  logic [REC_W-1:0]             stage_q [DEPTH];
  logic [REC_W-1:0]             stage_d [DEPTH];
  logic [CNT_W-1:0]             hazard_cnt_q;
  logic [CNT_W-1:0]             hazard_cnt_d;
  logic [REC_W-1:0]             w_ex_rec;
  logic [(DEPTH+1)*REC_W-1:0]   w_recs;
  logic [RD_PORTS-1:0]          w_hazard;
  logic [REC_W-1:0]             w_wb_rec;

  // Bubbles enter as all-zero records so wb_* stays quiet until real traffic.
  always_comb begin
    w_ex_rec = '0;
    if (ex_we_i) begin
      w_ex_rec[c_rec_valid]                   = 1'b1;
      w_ex_rec[c_rec_we]                      = 1'b1;
      w_ex_rec[c_rec_load]                    = ex_load_i;
      w_ex_rec[c_rec_ready]                   = !ex_load_i;
      w_ex_rec[c_rec_addr_lsb +: ADDR_W]      = ex_waddr_i;
      w_ex_rec[DATA_LSB +: DATA_W]            = ex_wdata_i;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] = '0;
      end
    end else if (!hold_i) begin
      stage_d[0] = w_ex_rec;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
        if ((i == int'(LOAD_RDY)) && stage_q[i-1][c_rec_valid] &&
            stage_q[i-1][c_rec_load] && !stage_q[i-1][c_rec_ready]) begin
          stage_d[i][DATA_LSB +: DATA_W] = mem_rdata_i;
          stage_d[i][c_rec_ready]        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (stall_req_o && (hazard_cnt_q != '1)) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
      hazard_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  always_comb begin
    w_recs[0 +: REC_W] = w_ex_rec;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_recs[(k+1)*REC_W +: REC_W] = stage_q[k];
    end
  end

  for (genvar p = 0; p < int'(RD_PORTS); p++) begin : g_port
    wb_fwd_pipe_fwd_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_fwd_sel (
      .re_i       (rd_re_i[p]),
      .addr_i     (rd_addr_i[p*ADDR_W +: ADDR_W]),
      .rf_rdata_i (rf_rdata_i[p*DATA_W +: DATA_W]),
      .recs_i     (w_recs),
      .data_o     (rd_data_o[p*DATA_W +: DATA_W]),
      .hazard_o   (w_hazard[p])
    );
  end

  assign stall_req_o = (|w_hazard) && !hold_i && !flush_i;

  assign w_wb_rec     = stage_q[DEPTH-1];
  assign wb_we_o      = w_wb_rec[c_rec_valid] && w_wb_rec[c_rec_we] && !hold_i &&
                        (w_wb_rec[c_rec_addr_lsb +: ADDR_W] != ADDR_W'(c_zero_reg));
  assign wb_waddr_o   = w_wb_rec[c_rec_addr_lsb +: ADDR_W];
  assign wb_wdata_o   = w_wb_rec[DATA_LSB +: DATA_W];
  assign hazard_cnt_o = hazard_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_fwd_pipe
// Purpose  : Self-checking bench for wb_fwd_pipe (DEPTH=4, RD_PORTS=3)
// Revision : 1.0
// ============================================================================
module tb_wb_fwd_pipe;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RD_PORTS = 3;
  localparam int unsigned LOAD_RDY = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        hold_i, flush_i, ex_we_i, ex_load_i;
  logic [ADDR_W-1:0]           ex_waddr_i;
  logic [DATA_W-1:0]           ex_wdata_i, mem_rdata_i;
  logic [RD_PORTS-1:0]         rd_re_i;
  logic [RD_PORTS*ADDR_W-1:0]  rd_addr_i;
  logic [RD_PORTS*DATA_W-1:0]  rf_rdata_i;
  logic [RD_PORTS*DATA_W-1:0]  rd_data_o;
  logic                        stall_req_o, wb_we_o;
  logic [ADDR_W-1:0]           wb_waddr_o;
  logic [DATA_W-1:0]           wb_wdata_o;
  logic [CNT_W-1:0]            hazard_cnt_o;

  always #5 clk = ~clk;

  wb_fwd_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_PORTS(RD_PORTS), .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
    .ex_we_i(ex_we_i), .ex_load_i(ex_load_i), .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i), .mem_rdata_i(mem_rdata_i), .rd_re_i(rd_re_i),
    .rd_addr_i(rd_addr_i), .rf_rdata_i(rf_rdata_i), .rd_data_o(rd_data_o),
    .stall_req_o(stall_req_o), .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o), .hazard_cnt_o(hazard_cnt_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: in-flight writes tagged by age ----------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                load;
    bit                ready;
    int                stage;
  } ent_t;

  ent_t        q[$];   // front = youngest
  int unsigned cnt_m = 0;

  function automatic void fwd_exp(input int p, output logic [DATA_W-1:0] d, output bit hz);
    logic [ADDR_W-1:0] a;
    bit hit;
    a   = rd_addr_i[p*ADDR_W +: ADDR_W];
    d   = '0;
    hz  = 1'b0;
    hit = 1'b0;
    if (rd_re_i[p] && a != '0) begin
      d = rf_rdata_i[p*DATA_W +: DATA_W];
      if (ex_we_i && ex_waddr_i == a) begin
        hit = 1'b1;
        if (ex_load_i) hz = 1'b1;
        else d = ex_wdata_i;
      end
      for (int s = 0; s < int'(DEPTH); s++) begin
        foreach (q[j]) begin
          if (!hit && q[j].stage == s && q[j].addr == a) begin
            hit = 1'b1;
            if (q[j].ready) d = q[j].data;
            else hz = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic bit stall_exp();
    logic [DATA_W-1:0] d;
    bit hz, any;
    any = 1'b0;
    for (int p = 0; p < int'(RD_PORTS); p++) begin
      fwd_exp(p, d, hz);
      any |= hz;
    end
    return any && !hold_i && !flush_i;
  endfunction

  function automatic void wb_exp(output bit we, output logic [ADDR_W-1:0] a,
                                 output logic [DATA_W-1:0] d);
    we = 1'b0;
    a  = '0;
    d  = '0;
    foreach (q[j]) begin
      if (q[j].stage == int'(DEPTH) - 1) begin
        a  = q[j].addr;
        d  = q[j].data;
        we = !hold_i && (q[j].addr != '0);
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (stall_exp() && cnt_m != CNT_MAX) cnt_m++;
      if (flush_i) begin
        q.delete();
      end else if (!hold_i) begin
        foreach (q[j]) begin
          if (q[j].load && !q[j].ready && q[j].stage == int'(LOAD_RDY) - 1) begin
            q[j].data  = mem_rdata_i;
            q[j].ready = 1'b1;
          end
          q[j].stage++;
        end
        while (q.size() > 0 && q[q.size()-1].stage >= int'(DEPTH)) void'(q.pop_back());
        if (ex_we_i)
          q.push_front('{addr: ex_waddr_i, data: ex_wdata_i, load: ex_load_i,
                         ready: !ex_load_i, stage: 0});
      end
    end
  end

  // Single compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    bit                we_e;
    logic [ADDR_W-1:0] a_e;
    logic [DATA_W-1:0] d_e;
    bit                hz;
    wb_exp(we_e, a_e, d_e);
    chk("m_wb_we",    64'(wb_we_o),      64'(we_e));
    chk("m_wb_waddr", 64'(wb_waddr_o),   64'(a_e));
    chk("m_wb_wdata", 64'(wb_wdata_o),   64'(d_e));
    chk("m_stall",    64'(stall_req_o),  64'(stall_exp()));
    chk("m_cnt",      64'(hazard_cnt_o), 64'(cnt_m));
    for (int p = 0; p < int'(RD_PORTS); p++) begin
      fwd_exp(p, d_e, hz);
      chk($sformatf("m_rd_data%0d", p), 64'(rd_data_o[p*DATA_W +: DATA_W]), 64'(d_e));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input bit we, input bit load, input int addr, input logic [31:0] data);
    ex_we_i    = we;
    ex_load_i  = load;
    ex_waddr_i = ADDR_W'(addr);
    ex_wdata_i = data;
  endtask

  task automatic rd(input int p, input bit re, input int addr, input logic [31:0] rf);
    rd_re_i[p]                       = re;
    rd_addr_i[p*ADDR_W +: ADDR_W]    = ADDR_W'(addr);
    rf_rdata_i[p*DATA_W +: DATA_W]   = rf;
  endtask

  task automatic idle();
    hold_i = 1'b0;
    flush_i = 1'b0;
    ex_drive(0, 0, 0, 32'h0);
    mem_rdata_i = '0;
    rd_re_i = '0;
    rd_addr_i = '0;
    rf_rdata_i = '0;
  endtask

  function automatic logic [DATA_W-1:0] rdp(input int p);
    return rd_data_o[p*DATA_W +: DATA_W];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_we"},    64'(wb_we_o),      64'd0);
    chk({tag, "_wb_waddr"}, 64'(wb_waddr_o),   64'd0);
    chk({tag, "_wb_wdata"}, 64'(wb_wdata_o),   64'd0);
    chk({tag, "_stall"},    64'(stall_req_o),  64'd0);
    chk({tag, "_cnt"},      64'(hazard_cnt_o), 64'd0);
    chk({tag, "_rd_data"},  64'(rd_data_o != '0), 64'd0);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");
    tick();

    // Back-to-back ALU dependency on r3
    ex_drive(1, 0, 3, 32'h11);
    rd(0, 1, 3, 32'hFFFF_0000);
    @(negedge clk);
    chk("A_fwd_ex", 64'(rdp(0)), 64'h11);
    chk("A_stall", 64'(stall_req_o), 64'd0);
    chk("A_port1_off", 64'(rdp(1)), 64'd0);
    tick();
    ex_drive(0, 0, 0, 32'h0);
    @(negedge clk);
    chk("A_fwd_s0", 64'(rdp(0)), 64'h11);
    tick();
    rd(0, 0, 0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    chk("A_wb_we", 64'(wb_we_o), 64'd1);
    chk("A_wb_waddr", 64'(wb_waddr_o), 64'd3);
    chk("A_wb_wdata", 64'(wb_wdata_o), 64'h11);
    tick();

    // Youngest match wins on r5
    ex_drive(1, 0, 5, 32'hAA);
    tick();
    ex_drive(1, 0, 5, 32'hBB);
    rd(1, 1, 5, 32'h0F0F_0F0F);
    @(negedge clk);
    chk("B_young_ex", 64'(rdp(1)), 64'hBB);
    tick();
    ex_drive(0, 0, 0, 32'h0);
    @(negedge clk);
    chk("B_young_s0", 64'(rdp(1)), 64'hBB);
    tick();
    rd(1, 0, 0, 32'h0);
    repeat (DEPTH) tick();

    // Load-use on r7: stalls until the captured load data reaches s[LOAD_RDY]
    ex_drive(1, 1, 7, 32'h1234);
    rd(2, 1, 7, 32'hCAFE);
    @(negedge clk);
    chk("C_stall_ex", 64'(stall_req_o), 64'd1);
    chk("C_cnt0", 64'(hazard_cnt_o), 64'd0);
    tick();
    ex_drive(0, 0, 0, 32'h0);
    mem_rdata_i = 32'hBAD0;
    @(negedge clk);
    chk("C_cnt1", 64'(hazard_cnt_o), 64'd1);
    chk("C_stall_s0", 64'(stall_req_o), 64'd1);
    tick();
    mem_rdata_i = 32'hDEAD;
    @(negedge clk);
    chk("C_stall_s1", 64'(stall_req_o), 64'd1);
    tick();
    mem_rdata_i = 32'h5A5A;
    @(negedge clk);
    chk("C_fwd_load", 64'(rdp(2)), 64'hDEAD);
    chk("C_stall_clr", 64'(stall_req_o), 64'd0);
    chk("C_cnt3", 64'(hazard_cnt_o), 64'd3);
    tick();
    @(negedge clk);
    chk("C_wb_we", 64'(wb_we_o), 64'd1);
    chk("C_wb_wdata", 64'(wb_wdata_o), 64'hDEAD);
    tick();
    idle();
    repeat (DEPTH) tick();

    // r0 never forwarded nor written
    ex_drive(1, 0, 0, 32'h55);
    rd(0, 1, 0, 32'h77);
    @(negedge clk);
    chk("D_r0_read", 64'(rdp(0)), 64'd0);
    tick();
    idle();
    repeat (3) tick();
    @(negedge clk);
    chk("D_r0_no_wb", 64'(wb_we_o), 64'd0);
    tick();
    repeat (DEPTH) tick();

    // Hold for three cycles, then flush with live entries behind the wb stage
    ex_drive(1, 0, 9, 32'h99);   tick();
    ex_drive(1, 0, 10, 32'hA0);  tick();
    ex_drive(1, 0, 11, 32'hB0);  tick();
    ex_drive(1, 0, 12, 32'hC0);  tick();
    hold_i = 1'b1;
    ex_drive(1, 1, 13, 32'h0);
    rd(1, 1, 13, 32'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("E_hold_we", 64'(wb_we_o), 64'd0);
      chk("E_hold_waddr", 64'(wb_waddr_o), 64'd9);
      chk("E_hold_stall", 64'(stall_req_o), 64'd0);
      tick();
    end
    hold_i = 1'b0;
    flush_i = 1'b1;
    ex_drive(0, 0, 0, 32'h0);
    rd(1, 0, 0, 32'h0);
    @(negedge clk);
    chk("E_flush_commit_we", 64'(wb_we_o), 64'd1);
    chk("E_flush_commit_wdata", 64'(wb_wdata_o), 64'h99);
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      chk("E_killed_we", 64'(wb_we_o), 64'd0);
      tick();
    end

    // Saturate the hazard counter, then reset asynchronously mid-stream
    rd(0, 1, 7, 32'h1);
    for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
      ex_drive(1, 1, 7, 32'(i));
      mem_rdata_i = 32'(i) ^ 32'h0000_FFFF;
      tick();
    end
    @(negedge clk);
    chk("F_cnt_sat", 64'(hazard_cnt_o), 64'hFFFF);
    chk("F_live_wb", 64'(wb_we_o), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle();
    #1;
    chk_all_zero("F_async_rst");
    @(negedge clk);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("F_after_we", 64'(wb_we_o), 64'd0);
    chk("F_after_cnt", 64'(hazard_cnt_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
